// File: rtl/lock_pkg.sv
// Shared constants, state type and helpers for the lock-in demodulator slice.
package lock_pkg;

  localparam int REF_W         = 14;
  localparam int PROD_W        = 28;
  localparam int ACC_W_DEFAULT = 56;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    ACC  = 2'd2
  } lock_state_t;

  // Limit a requested averaging exponent to the largest one the period counter can hold.
  function automatic logic [3:0] clamp_avg(input logic [3:0] avg, input int max_log2);
    if (int'(avg) > max_log2) begin
      return 4'(max_log2);
    end
    return avg;
  endfunction

endpackage

// File: rtl/lock_demod_mac.sv
// One demodulator channel: input register, signed multiply, wrapping accumulator
// and the output register loaded with accumulator plus the current product on dump.
module lock_demod_mac
  import lock_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [REF_W-1:0] sig_in,
  input  logic signed [REF_W-1:0] ref_in,
  input  logic                    acc_en,
  input  logic                    dump,
  input  logic                    clear,
  output logic signed [ACC_W-1:0] result
);

  logic signed [REF_W-1:0]  sig_r;
  logic signed [REF_W-1:0]  ref_r;
  logic signed [PROD_W-1:0] prod_r;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;

  assign prod_ext = {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
  assign acc_sum  = acc + prod_ext;

  // Stage 1: capture sample and reference together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_r <= '0;
      ref_r <= '0;
    end else begin
      sig_r <= sig_in;
      ref_r <= ref_in;
    end
  end

  // Stage 2: full-precision signed product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_r <= '0;
    end else begin
      prod_r <= PROD_W'(sig_r) * PROD_W'(ref_r);
    end
  end

  // Stage 3: accumulate, or hand the finished sum to the output and restart from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      result <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (dump) begin
      acc    <= '0;
      result <= acc_sum;
    end else if (acc_en) begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/lock_demod_h.sv
// Lock-in demodulator top: three-stage pipeline, IDLE/ARM/ACC control and result handshake.
// Optional second-harmonic channel (cos_2f -> x2_out) is built when LOCK_DEMOD_2F_EN is defined.
module lock_demod_h
  import lock_pkg::*;
#(
  parameter int ACC_W        = ACC_W_DEFAULT,
  parameter int AVG_MAX_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [3:0]              avg_log2,
  input  logic signed [REF_W-1:0] sig_in,
  input  logic signed [REF_W-1:0] sin_ref,
  input  logic signed [REF_W-1:0] cos_ref,
  input  logic                    harmonic_trig,
`ifdef LOCK_DEMOD_2F_EN
  input  logic signed [REF_W-1:0] cos_2f,
  output logic signed [ACC_W-1:0] x2_out,
`endif
  output logic signed [ACC_W-1:0] x_out,
  output logic signed [ACC_W-1:0] y_out,
  output logic [31:0]             n_samp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int PER_W = AVG_MAX_LOG2 + 1;

  lock_state_t      state;
  lock_state_t      next_state;
  logic             trig_s1;
  logic             trig_s2;
  logic             acc_en;
  logic             dump;
  logic             clear;
  logic             avg_load;
  logic [3:0]       avg_cur;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] per_target;
  logic             last_period;
  logic [31:0]      samp_cnt;
  logic [31:0]      samp_next;

  assign per_target  = PER_W'(1) << avg_cur;
  assign last_period = (per_cnt + PER_W'(1)) == per_target;
  assign samp_next   = (samp_cnt == 32'hFFFF_FFFF) ? samp_cnt : samp_cnt + 32'd1;
  assign avg_load    = ((state != ACC) && (next_state == ACC)) || dump;

  // Delay the trigger through the same two stages as the data it marks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
    end else begin
      trig_s1 <= harmonic_trig;
      trig_s2 <= trig_s1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and per-sample accumulate/dump/clear decisions; enable low overrides everything.
  always_comb begin
    next_state = state;
    acc_en     = 1'b0;
    dump       = 1'b0;
    clear      = 1'b0;
    if (!enable) begin
      next_state = IDLE;
      clear      = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          clear      = 1'b1;
          next_state = ARM;
        end
        ARM: begin
          clear = 1'b1;
          if (trig_s2) begin
            next_state = ACC;
          end
        end
        ACC: begin
          if (trig_s2 && last_period) begin
            dump = 1'b1;
          end else begin
            acc_en = 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
          clear      = 1'b1;
        end
      endcase
    end
  end

  // Averaging length is only picked up when integration starts or restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avg_cur <= '0;
    end else if (avg_load) begin
      avg_cur <= clamp_avg(avg_log2, AVG_MAX_LOG2);
    end
  end

  // Period and sample counters for the result being integrated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt  <= '0;
      samp_cnt <= '0;
    end else if (clear || dump) begin
      per_cnt  <= '0;
      samp_cnt <= '0;
    end else if (acc_en) begin
      samp_cnt <= samp_next;
      if (trig_s2) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
    end
  end

  // Result handshake: a new load wins over a transfer, and a load onto an untaken result flags overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      n_samp    <= '0;
    end else begin
      if (dump) begin
        out_valid <= 1'b1;
        n_samp    <= samp_next;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (!enable) begin
        overrun <= 1'b0;
      end
    end
  end

  lock_demod_mac #(.ACC_W(ACC_W)) u_mac_x (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .ref_in (cos_ref),
    .acc_en (acc_en),
    .dump   (dump),
    .clear  (clear),
    .result (x_out)
  );

  lock_demod_mac #(.ACC_W(ACC_W)) u_mac_y (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .ref_in (sin_ref),
    .acc_en (acc_en),
    .dump   (dump),
    .clear  (clear),
    .result (y_out)
  );

`ifdef LOCK_DEMOD_2F_EN
  lock_demod_mac #(.ACC_W(ACC_W)) u_mac_x2 (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .ref_in (cos_2f),
    .acc_en (acc_en),
    .dump   (dump),
    .clear  (clear),
    .result (x2_out)
  );
`endif

endmodule
